fmul_seq: RTL and testbench



---
 rtl/fmul_seq.sv | 117 +++++++++++
 tb/tb_fmul_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fmul_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier: one shift-add step per clock,
// truncating, zero/inf conventions matching the downstream float adder.
module fmul_seq #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MUL     = 2'd1;
  localparam logic [1:0] S_NORM    = 2'd2;
  localparam logic [1:0] S_SPECIAL = 2'd3;

  logic [1:0]        state;
  logic [4:0]        cnt;
  logic              sign;
  logic              op_zero;
  logic              op_inf;
  logic signed [9:0] exp_sum;
  logic [23:0]       mcand;
  logic [47:0]       prod;

  logic              in_zero;
  logic              in_inf;
  logic [24:0]       partial;
  logic signed [9:0] exp_n;
  logic [22:0]       frac_n;
  logic [31:0]       inf_word;
  logic [31:0]       norm_word;

  assign busy    = (state != S_IDLE);
  assign in_zero = (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
  assign in_inf  = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);

  // prod holds {partial high half, remaining multiplier bits}; shifting right
  // each step retires one multiplier bit and leaves the exact product after 24.
  always_comb begin
    partial  = {1'b0, prod[47:24]} + (prod[0] ? {1'b0, mcand} : 25'd0);
    inf_word = {sign, 8'hFF, 23'h0};
    if (prod[47]) begin
      exp_n  = exp_sum + 10'sd1;
      frac_n = prod[46:24];
    end else begin
      exp_n  = exp_sum;
      frac_n = prod[45:23];
    end
    if (op_zero)
      norm_word = '0;
    else if (op_inf)
      norm_word = inf_word;
    else if (exp_n >= 10'sd255)
      norm_word = inf_word;
    else if (exp_n <= 10'sd0)
      norm_word = '0;
    else
      norm_word = {sign, exp_n[7:0], frac_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sign    <= 1'b0;
      op_zero <= 1'b0;
      op_inf  <= 1'b0;
      exp_sum <= '0;
      mcand   <= '0;
      prod    <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sign    <= a[31] ^ b[31];
            exp_sum <= $signed({2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127);
            mcand   <= {1'b1, a[22:0]};
            prod    <= {24'd0, 1'b1, b[22:0]};
            op_zero <= in_zero;
            op_inf  <= in_inf;
            cnt     <= '0;
            state   <= (EARLY_OUT && (in_zero || in_inf)) ? S_SPECIAL : S_MUL;
          end
        end
        S_MUL: begin
          prod <= {partial, prod[23:1]};
          if (cnt == 5'd23) begin
            cnt   <= '0;
            state <= S_NORM;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_NORM: begin
          result <= norm_word;
          done   <= 1'b1;
          state  <= S_IDLE;
        end
        S_SPECIAL: begin
          result <= op_zero ? 32'h0 : inf_word;
          done   <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_seq.sv
// Self-checking bench for fmul_seq: both EARLY_OUT settings side by side,
// checked against an integer-arithmetic model of the multiply rules.
module tb_fmul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy1, done1, busy0, done0;
  logic [31:0] res1, res0;

  int n_pass  = 0;
  int n_total = 0;

  fmul_seq #(.EARLY_OUT(1'b1)) u_eo (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(res1)
  );

  fmul_seq #(.EARLY_OUT(1'b0)) u_full (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .result(res0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    int unsigned ex, ey;
    int          e;
    logic        s;
    logic [47:0] p;
    logic [22:0] f;
    s  = x[31] ^ y[31];
    ex = x[30:23];
    ey = y[30:23];
    if (ex == 0 || ey == 0) return 32'h0;
    if (ex == 255 || ey == 255) return {s, 8'hFF, 23'h0};
    p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = int'(ex) + int'(ey) - 127;
    if (p[47]) begin
      f = p[46:24];
      e = e + 1;
    end else begin
      f = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return 32'h0;
    return {s, 8'(e), f};
  endfunction

  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return x[30:23] == 8'h00 || y[30:23] == 8'h00 || x[30:23] == 8'hFF || y[30:23] == 8'hFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Launch one operation on both instances and watch a fixed window after accept.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] exp_r;
    int          lat1, lat0, n1, n0;
    logic [31:0] r1, r0;
    exp_r = model(x, y);
    lat1 = -1; lat0 = -1; n1 = 0; n0 = 0; r1 = 'x; r0 = 'x;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    check({tag, " busy_eo"}, 32'(busy1), 32'd1);
    check({tag, " busy_full"}, 32'(busy0), 32'd1);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done1) begin n1++; if (lat1 < 0) begin lat1 = k; r1 = res1; end end
      if (done0) begin n0++; if (lat0 < 0) begin lat0 = k; r0 = res0; end end
    end
    check({tag, " lat_eo"}, 32'(lat1), is_special(x, y) ? 32'd1 : 32'd25);
    check({tag, " lat_full"}, 32'(lat0), 32'd25);
    check({tag, " pulses_eo"}, 32'(n1), 32'd1);
    check({tag, " pulses_full"}, 32'(n0), 32'd1);
    check({tag, " res_eo"}, r1, exp_r);
    check({tag, " res_full"}, r0, exp_r);
    check({tag, " held_eo"}, res1, exp_r);
    check({tag, " held_full"}, res0, exp_r);
  endtask

  initial begin
    logic [31:0] va [11];
    logic [31:0] vb [11];
    logic [31:0] x, y;
    int          lat, n;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {busy1, busy0}, 32'd0);
    check("reset done", {done1, done0}, 32'd0);
    check("reset res_eo", res1, 32'h0);
    check("reset res_full", res0, 32'h0);
    rst_n = 1'b1;

    va[0] = 32'h3FC00000; vb[0] = 32'h40000000;
    va[1] = 32'h3FC00000; vb[1] = 32'h3FC00000;
    va[2] = 32'hC0000000; vb[2] = 32'h3F000000;
    va[3] = 32'h7F000000; vb[3] = 32'h40000000;
    va[4] = 32'h00800000; vb[4] = 32'h00800000;
    va[5] = 32'hFF000000; vb[5] = 32'h40000000;
    va[6] = 32'h00000000; vb[6] = 32'h40400000;
    va[7] = 32'h7F800000; vb[7] = 32'hBF800000;
    va[8] = 32'h80123456; vb[8] = 32'h7F800000;
    va[9] = 32'h3FFFFFFF; vb[9] = 32'h3FFFFFFF;
    va[10] = 32'h7FFFFFFF; vb[10] = 32'h3F800000;
    for (int i = 0; i < 11; i++) run_op($sformatf("dir%0d", i), va[i], vb[i]);

    for (int i = 0; i < 24; i++) begin
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 7))
        0: x[30:23] = 8'h00;
        1: y[30:23] = 8'hFF;
        2: begin x[30:23] = 8'(190 + $urandom_range(0, 60)); y[30:23] = 8'(190 + $urandom_range(0, 60)); end
        3: begin x[30:23] = 8'($urandom_range(1, 64)); y[30:23] = 8'($urandom_range(1, 64)); end
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), x, y);
    end

    // Starts while busy must be ignored.
    x = 32'h40490FDB; y = 32'hC02DF854;
    @(negedge clk); a = x; b = y; start = 1'b1;
    @(negedge clk); start = 1'b0; a = $urandom; b = $urandom;
    lat = -1; n = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done1) begin n++; if (lat < 0) begin lat = k; check("ign res_eo", res1, model(x, y)); end end
      if (k == 5 || k == 20) begin a = 32'h3F800000; b = 32'h3F800000; start = 1'b1; end
      else start = 1'b0;
    end
    check("ign lat", 32'(lat), 32'd25);
    check("ign pulses", 32'(n), 32'd1);
    check("ign res_full", res0, model(x, y));

    // Start in the done cycle is accepted.
    x = 32'h41200000; y = 32'h3DCCCCCD;
    @(negedge clk); a = x; b = y; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      @(negedge clk);
      if (done1) lat = k;
    end
    check("bb first lat", 32'(lat), 32'd25);
    check("bb first res", res1, model(x, y));
    x = 32'hC1A00000; y = 32'h3E800000;
    a = x; b = y; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("bb done width", {done1, done0}, 32'd0);
    check("bb busy again", 32'(busy1), 32'd1);
    lat = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      @(negedge clk);
      if (done1) lat = k;
    end
    check("bb second lat", 32'(lat), 32'd25);
    check("bb second res_eo", res1, model(x, y));
    check("bb second res_full", res0, model(x, y));

    // Asynchronous reset mid-operation.
    run_op("pre_rst", 32'h3FC00000, 32'h40000000);
    @(negedge clk); a = 32'h40800000; b = 32'h40800000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", {busy1, busy0}, 32'd0);
    check("rst done", {done1, done0}, 32'd0);
    check("rst res_eo", res1, 32'h0);
    check("rst res_full", res0, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done1 || done0) n++;
    end
    check("rst no done", 32'(n), 32'd0);
    run_op("post_rst", 32'h40800000, 32'h40800000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
